colour_pattern_gen: RTL and testbench
=====================================

// Module: colour_pattern_gen
// PURPOSE
//  Pixel-colour source directly upstream of the VGA timing interface: consumes its pixel address
//  (ADDRESS_H/ADDRESS_V) and returns the 12-bit RGB colour it samples as COLOUR_IN.
//  Draws one of four test patterns from a foreground colour stepped round a 6-state hue wheel
//  every CYCLE_FRAMES frames, plus a background colour. Pattern mode changes only on frame
//  boundaries, so a frame never tears.
// PARAMETERS
//  CYCLE_FRAMES  60   frames per hue step; legal range 1..1023
//  V_PIX         480  visible lines; ADDRESS_V == V_PIX-1 marks the last visible line
//  H_PIX         640  visible pixels per line; used only by BORDER_EN
// PORTS
//  CLK          in   1   system clock (same clock as the VGA interface)
//  RESET        in   1   synchronous, active-low reset
//  ADDRESS_H    in   10  current pixel column from the VGA interface (0..H_PIX-1)
//  ADDRESS_V    in   9   current pixel row from the VGA interface (0..V_PIX-1)
//  MODE         in   2   requested pattern; 0 solid, 1 checker, 2 stripes, 3 gradient
//  BASE_COLOUR  in   12  background colour {R[3:0],G[3:0],B[3:0]}
//  FREEZE       in   1   1 = hold the hue state and the frame counter
//  COLOUR_OUT   out  12  pixel colour; drives the VGA interface COLOUR_IN
//  FRAME_TICK   out  1   one-CLK pulse at the end of each frame
// BEHAVIOUR
//  Reset (RESET==0 at a CLK edge): COLOUR_OUT=0, FRAME_TICK=0, hue state=S_R, frame_cnt=0,
//   mode_q=0, v_prev=0. Reset overrides every other input, including mid-frame.
//  Frame detect: v_prev <= ADDRESS_V every CLK.
//   FRAME_TICK <= (v_prev==V_PIX-1) && (ADDRESS_V==0); registered, so exactly 1 CLK wide.
//  Mode latch: mode_q <= MODE only in the cycle FRAME_TICK is asserted. Never at any other time.
//  Frame counter: width $clog2(CYCLE_FRAMES+1).
//   On FRAME_TICK with FREEZE=0: if frame_cnt==CYCLE_FRAMES-1, frame_cnt<=0 and hue advances;
//   otherwise frame_cnt increments.
//   FREEZE=1: counter and hue hold; FRAME_TICK and the mode latch still operate.
//   CYCLE_FRAMES=1: hue advances on every unfrozen FRAME_TICK.
//  Hue FSM: S_R->S_RG->S_G->S_GB->S_B->S_BR->S_R (wraps). fg colour per state:
//   F00, FF0, 0F0, 0FF, 00F, F0F (hex). Unused encodings return to S_R.
//  Pattern selection (combinational from the current address, mode_q and fg):
//   mode 0: fg
//   mode 1: (ADDRESS_H[5]^ADDRESS_V[5]) ? fg : BASE_COLOUR   (32x32 checkerboard)
//   mode 2: ADDRESS_H[6] ? fg : BASE_COLOUR                  (64-pixel vertical stripes)
//   mode 3: {ADDRESS_H[9:6], ADDRESS_V[8:5], fg[3:0]}       (R=column band, G=row band, B=fg blue)
//  Output: COLOUR_OUT registered; latency 1 CLK from ADDRESS_H/ADDRESS_V to COLOUR_OUT.
//   Every CLK edge with RESET high loads the next value; there is no enable.
//  Boundary cases:
//   - FRAME_TICK and a MODE change in the same cycle: the new MODE is captured.
//   - ADDRESS_V held at 0 through vertical blanking: v_prev != V_PIX-1, so no second tick.
//   - The hue step and mode_q both take effect on the first pixel of the next frame.
// CONFIGURATION
//  BORDER_EN defined: after pattern selection, pixels with ADDRESS_H==0, ADDRESS_H==H_PIX-1,
//   ADDRESS_V==0 or ADDRESS_V==V_PIX-1 output 12'hFFF. Latency stays 1 CLK.
//  BORDER_EN undefined: no border logic; the pattern output is unmodified.
// TESTING
//  1. Reset asserted mid-frame with MODE=1 -> next edge COLOUR_OUT=0, FRAME_TICK=0,
//     then fg=F00 and mode_q=0.
//  2. MODE=0, CYCLE_FRAMES=2, FREEZE=0, drive 4 frames -> COLOUR_OUT F00,F00,FF0,FF0;
//     FRAME_TICK pulses 4 times, each 1 CLK wide.
//  3. MODE 0->1 mid-frame -> current frame stays solid;
//     after FRAME_TICK, (H=32,V=0) gives fg and (H=32,V=32) gives BASE_COLOUR.
//  4. FREEZE=1 across 3*CYCLE_FRAMES frames in state S_G -> fg stays 0F0; frame_cnt unchanged.
//  5. CYCLE_FRAMES=1, 7 frames -> hue S_R..S_BR then wraps to S_R (F00 on frame 7).
//  6. BORDER_EN, MODE=0, BASE_COLOUR=0 -> (0,100)=FFF, (639,5)=FFF, (100,479)=FFF, (100,100)=F00;
//     mode 3 at (128,64) with fg F00 -> 12'h220.

Source files
------------

// File: rtl/colour_pattern_gen_if.sv
// colour_pattern_gen_if: pixel address/control from the VGA side and the colour/frame-tick response
interface colour_pattern_gen_if;
  logic [9:0] ADDRESS_H;
  logic [8:0] ADDRESS_V;
  logic [1:0] MODE;
  logic [11:0] BASE_COLOUR;
  logic FREEZE;
  logic [11:0] COLOUR_OUT;
  logic FRAME_TICK;
  modport master (output ADDRESS_H, ADDRESS_V, MODE, BASE_COLOUR, FREEZE, input COLOUR_OUT, FRAME_TICK);
  modport slave (input ADDRESS_H, ADDRESS_V, MODE, BASE_COLOUR, FREEZE, output COLOUR_OUT, FRAME_TICK);
endinterface

// File: rtl/colour_pattern_gen.sv
// colour_pattern_gen: hue-cycling four-mode VGA test-pattern source; define BORDER_EN for a white frame border
module colour_pattern_gen #(
  parameter int CYCLE_FRAMES = 60,
  parameter int V_PIX = 480,
  parameter int H_PIX = 640
) (
  input logic CLK,
  input logic RESET,
  colour_pattern_gen_if.slave bus
);
  localparam int CW = $clog2(CYCLE_FRAMES + 1);
  typedef enum logic [2:0] {S_R, S_RG, S_G, S_GB, S_B, S_BR} hue_t;
  hue_t hue, hue_nx;
  logic [CW-1:0] frame_cnt;
  logic [8:0] v_prev;
  logic [1:0] mode_q;
  logic tick_q, last, step;
  logic [11:0] fg, pat, pix, colour_q;
  assign last = frame_cnt == CW'(CYCLE_FRAMES - 1);
  assign step = tick_q && !bus.FREEZE && last;
  always_comb begin
    hue_nx = hue;
    fg = 12'hF00;
    case (hue)
      S_R: begin fg = 12'hF00; hue_nx = step ? S_RG : S_R; end
      S_RG: begin fg = 12'hFF0; hue_nx = step ? S_G : S_RG; end
      S_G: begin fg = 12'h0F0; hue_nx = step ? S_GB : S_G; end
      S_GB: begin fg = 12'h0FF; hue_nx = step ? S_B : S_GB; end
      S_B: begin fg = 12'h00F; hue_nx = step ? S_BR : S_B; end
      S_BR: begin fg = 12'hF0F; hue_nx = step ? S_R : S_BR; end
      default: hue_nx = S_R;
    endcase
  end
  always_comb begin
    pat = mode_q == 2'd0 ? fg :
          mode_q == 2'd1 ? ((bus.ADDRESS_H[5] ^ bus.ADDRESS_V[5]) ? fg : bus.BASE_COLOUR) :
          mode_q == 2'd2 ? (bus.ADDRESS_H[6] ? fg : bus.BASE_COLOUR) :
          {bus.ADDRESS_H[9:6], bus.ADDRESS_V[8:5], fg[3:0]};
`ifdef BORDER_EN
    pix = (bus.ADDRESS_H == 10'd0 || bus.ADDRESS_H == 10'(H_PIX - 1) ||
           bus.ADDRESS_V == 9'd0 || bus.ADDRESS_V == 9'(V_PIX - 1)) ? 12'hFFF : pat;
`else
    pix = pat;
`endif
  end
`ifndef BORDER_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.ADDRESS_H[4:0], 10'(H_PIX)};
`endif
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hue <= S_R;
      frame_cnt <= '0;
      v_prev <= '0;
      mode_q <= '0;
      tick_q <= 1'b0;
      colour_q <= '0;
    end else begin
      hue <= hue_nx;
      v_prev <= bus.ADDRESS_V;
      tick_q <= v_prev == 9'(V_PIX - 1) && bus.ADDRESS_V == 9'd0;
      colour_q <= pix;
      if (tick_q) mode_q <= bus.MODE;
      if (tick_q && !bus.FREEZE) frame_cnt <= last ? '0 : frame_cnt + 1'b1;
    end
  end
  assign bus.COLOUR_OUT = colour_q;
  assign bus.FRAME_TICK = tick_q;
endmodule

// File: tb/tb_colour_pattern_gen.sv
// tb_colour_pattern_gen: scoreboarded bench driving two instances (CYCLE_FRAMES 2 and 1) with sparse frames
module tb_colour_pattern_gen;
  localparam int V_PIX = 480;
  typedef struct {
    logic [11:0] c;
    logic t;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [11:0] base = 12'h000;
  logic freeze = 1'b0;
  logic [8:0] m_vprev = 9'd0;
  logic m_tick = 1'b0;
  logic [1:0] m_mode = 2'd0;
  int m_cnt = 0, m_hue0 = 0, m_hue1 = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0, ticks_seen = 0;
  always #5 clk = ~clk;
  colour_pattern_gen_if b0();
  colour_pattern_gen_if b1();
  colour_pattern_gen #(.CYCLE_FRAMES(2)) u0 (.CLK(clk), .RESET(reset_n), .bus(b0));
  colour_pattern_gen #(.CYCLE_FRAMES(1)) u1 (.CLK(clk), .RESET(reset_n), .bus(b1));
  function automatic logic [11:0] fg_of(int hue);
    case (hue)
      0: return 12'hF00;
      1: return 12'hFF0;
      2: return 12'h0F0;
      3: return 12'h0FF;
      4: return 12'h00F;
      default: return 12'hF0F;
    endcase
  endfunction
  function automatic logic [11:0] exp_col(logic [9:0] h, logic [8:0] v, logic [1:0] m, int hue);
    logic [11:0] fg, c;
    fg = fg_of(hue);
    case (m)
      2'd0: c = fg;
      2'd1: c = (h[5] ^ v[5]) ? fg : base;
      2'd2: c = h[6] ? fg : base;
      default: c = {h[9:6], v[8:5], fg[3:0]};
    endcase
`ifdef BORDER_EN
    if (h == 10'd0 || h == 10'd639 || v == 9'd0 || v == 9'd479) c = 12'hFFF;
`endif
    return c;
  endfunction
  always @(posedge clk) begin
    #1;
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks += 2;
      if (b0.COLOUR_OUT !== e0.c || b0.FRAME_TICK !== e0.t) begin
        errors++;
        $display("FAIL sb_u0 @%0t: colour/tick got %h/%b want %h/%b", $time, b0.COLOUR_OUT, b0.FRAME_TICK, e0.c, e0.t);
      end
      if (b1.COLOUR_OUT !== e1.c || b1.FRAME_TICK !== e1.t) begin
        errors++;
        $display("FAIL sb_u1 @%0t: colour/tick got %h/%b want %h/%b", $time, b1.COLOUR_OUT, b1.FRAME_TICK, e1.c, e1.t);
      end
      if (b0.FRAME_TICK === 1'b1) ticks_seen++;
    end
  end
  task automatic pix(input logic [9:0] h, input logic [8:0] v);
    logic nt;
    exp_t x0, x1;
    @(negedge clk);
    b0.ADDRESS_H = h; b0.ADDRESS_V = v; b0.MODE = mode; b0.BASE_COLOUR = base; b0.FREEZE = freeze;
    b1.ADDRESS_H = h; b1.ADDRESS_V = v; b1.MODE = mode; b1.BASE_COLOUR = base; b1.FREEZE = freeze;
    if (!reset_n) begin
      x0.c = 12'h000; x0.t = 1'b0; x1 = x0;
      m_vprev = 9'd0; m_tick = 1'b0; m_mode = 2'd0; m_cnt = 0; m_hue0 = 0; m_hue1 = 0;
    end else begin
      nt = (m_vprev == 9'(V_PIX - 1)) && (v == 9'd0);
      x0.c = exp_col(h, v, m_mode, m_hue0); x0.t = nt;
      x1.c = exp_col(h, v, m_mode, m_hue1); x1.t = nt;
      if (m_tick) begin
        m_mode = mode;
        if (!freeze) begin
          m_hue1 = (m_hue1 + 1) % 6;
          if (m_cnt == 1) begin
            m_cnt = 0;
            m_hue0 = (m_hue0 + 1) % 6;
          end else m_cnt++;
        end
      end
      m_vprev = v;
      m_tick = nt;
    end
    q0.push_back(x0);
    q1.push_back(x1);
    @(posedge clk);
    #1;
  endtask
  task automatic boundary();
    pix(10'd200, 9'd479);
    pix(10'd0, 9'd0);
    pix(10'd0, 9'd0);
    pix(10'd0, 9'd0);
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    pix(10'd0, 9'd0);
    pix(10'd0, 9'd0);
    checks++;
    if (b0.COLOUR_OUT !== 12'h000 || b0.FRAME_TICK !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got %h/%b want 000/0", b0.COLOUR_OUT, b0.FRAME_TICK);
    end
    reset_n = 1'b1;
    mode = 2'd1;
    pix(10'd100, 9'd100);
    boundary();
    pix(10'd32, 9'd100);
    pix(10'd100, 9'd200);
    reset_n = 1'b0;
    pix(10'd300, 9'd250);
    checks++;
    if (b0.COLOUR_OUT !== 12'h000 || b0.FRAME_TICK !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: got %h/%b want 000/0", b0.COLOUR_OUT, b0.FRAME_TICK);
    end
    reset_n = 1'b1;
    pix(10'd100, 9'd100);
    checks++;
    if (b0.COLOUR_OUT !== 12'hF00 || b1.COLOUR_OUT !== 12'hF00) begin
      errors++;
      $display("FAIL reset_solid_red: got %h,%h want F00", b0.COLOUR_OUT, b1.COLOUR_OUT);
    end
    mode = 2'd0;
  endtask
  task automatic test_hue_cycle();
    int t0;
    t0 = ticks_seen;
    for (int f = 0; f < 4; f++) begin
      pix(10'd100, 9'd100);
      checks++;
      if (b0.COLOUR_OUT !== ((f < 2) ? 12'hF00 : 12'hFF0)) begin
        errors++;
        $display("FAIL hue_cycle frame %0d: got %h want %h", f, b0.COLOUR_OUT, (f < 2) ? 12'hF00 : 12'hFF0);
      end
      boundary();
    end
    checks++;
    if (ticks_seen - t0 != 4) begin
      errors++;
      $display("FAIL hue_cycle ticks: got %0d want 4", ticks_seen - t0);
    end
  endtask
  task automatic test_freeze();
    freeze = 1'b1;
    for (int f = 0; f < 6; f++) begin
      pix(10'd100, 9'd100);
      checks++;
      if (b0.COLOUR_OUT !== 12'h0F0) begin
        errors++;
        $display("FAIL freeze frame %0d: got %h want 0F0", f, b0.COLOUR_OUT);
      end
      boundary();
    end
    checks++;
    if (u0.frame_cnt !== '0) begin
      errors++;
      $display("FAIL freeze frame_cnt: got %0d want 0", u0.frame_cnt);
    end
    freeze = 1'b0;
  endtask
  task automatic test_mode_change();
    base = 12'h123;
    pix(10'd100, 9'd100);
    mode = 2'd1;
    pix(10'd32, 9'd32);
    checks++;
    if (b0.COLOUR_OUT !== 12'h0F0) begin
      errors++;
      $display("FAIL mode_midframe: got %h want 0F0", b0.COLOUR_OUT);
    end
    boundary();
    pix(10'd32, 9'd64);
    checks++;
    if (b0.COLOUR_OUT !== 12'h0F0) begin
      errors++;
      $display("FAIL checker_fg: got %h want 0F0", b0.COLOUR_OUT);
    end
    pix(10'd32, 9'd32);
    checks++;
    if (b0.COLOUR_OUT !== 12'h123) begin
      errors++;
      $display("FAIL checker_base: got %h want 123", b0.COLOUR_OUT);
    end
  endtask
  task automatic test_back_to_back();
    pix(10'd200, 9'd479);
    pix(10'd0, 9'd0);
    mode = 2'd2;
    pix(10'd0, 9'd0);
    pix(10'd0, 9'd0);
    checks++;
    if (b0.FRAME_TICK !== 1'b0) begin
      errors++;
      $display("FAIL blanking_tick: got %b want 0", b0.FRAME_TICK);
    end
    pix(10'd64, 9'd100);
    checks++;
    if (b0.COLOUR_OUT !== 12'h0FF) begin
      errors++;
      $display("FAIL stripe_fg: got %h want 0FF", b0.COLOUR_OUT);
    end
    pix(10'd10, 9'd100);
    checks++;
    if (b0.COLOUR_OUT !== 12'h123) begin
      errors++;
      $display("FAIL stripe_base: got %h want 123", b0.COLOUR_OUT);
    end
  endtask
  task automatic test_wrap();
    logic [11:0] seq [7];
    seq = '{12'hF00, 12'hFF0, 12'h0F0, 12'h0FF, 12'h00F, 12'hF0F, 12'hF00};
    reset_n = 1'b0;
    mode = 2'd0;
    pix(10'd0, 9'd0);
    reset_n = 1'b1;
    for (int f = 0; f < 7; f++) begin
      pix(10'd100, 9'd100);
      checks++;
      if (b1.COLOUR_OUT !== seq[f]) begin
        errors++;
        $display("FAIL wrap frame %0d: got %h want %h", f, b1.COLOUR_OUT, seq[f]);
      end
      boundary();
    end
  endtask
  task automatic test_gradient();
    reset_n = 1'b0;
    pix(10'd0, 9'd0);
    reset_n = 1'b1;
    mode = 2'd3;
    pix(10'd100, 9'd100);
    boundary();
    pix(10'd128, 9'd64);
    checks++;
    if (b0.COLOUR_OUT !== 12'h220 || b1.COLOUR_OUT !== 12'h220) begin
      errors++;
      $display("FAIL gradient: got %h,%h want 220", b0.COLOUR_OUT, b1.COLOUR_OUT);
    end
  endtask
`ifdef BORDER_EN
  task automatic test_border();
    logic [9:0] hs [4];
    logic [8:0] vs [4];
    logic [11:0] ws [4];
    hs = '{10'd0, 10'd639, 10'd100, 10'd100};
    vs = '{9'd100, 9'd5, 9'd479, 9'd100};
    ws = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hF00};
    reset_n = 1'b0;
    mode = 2'd0;
    base = 12'h000;
    pix(10'd50, 9'd50);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix(hs[i], vs[i]);
      checks++;
      if (b0.COLOUR_OUT !== ws[i]) begin
        errors++;
        $display("FAIL border %0d: got %h want %h", i, b0.COLOUR_OUT, ws[i]);
      end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_hue_cycle();
    test_freeze();
    test_mode_change();
    test_back_to_back();
    test_wrap();
    test_gradient();
`ifdef BORDER_EN
    test_border();
`endif
    @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q0.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
